fft16_frame_seq: RTL and testbench

//  Frame sequencer for the 16-point streaming FFT core. Collects 16 complex samples

---
 rtl/fft16_frame_seq.sv | 189 ++++++++++++++++++
 tb/tb_fft16_frame_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_frame_seq.sv
// rtl/fft16_frame_seq.sv - frame sequencer between valid/ready sample streams and a 16-point streaming FFT core
// Input bank fills while the output bank drains; one START + continuous ED burst per frame.
module fft16_frame_seq #(
  parameter int NB          = 32,
  parameter int CAP_OFS     = 0,
  parameter int RDY_TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [NB-1:0] IN_RE,
  input  logic [NB-1:0] IN_IM,
  input  logic          IN_IFFT,
  output logic          FFT_ED,
  output logic          FFT_START,
  output logic          FFT_IFFT,
  output logic [NB-1:0] FFT_DIR,
  output logic [NB-1:0] FFT_DII,
  input  logic          FFT_RDY,
  input  logic [NB+3:0] FFT_DOR,
  input  logic [NB+3:0] FFT_DOI,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [NB+3:0] OUT_RE,
  output logic [NB+3:0] OUT_IM,
  output logic [3:0]    OUT_IDX,
  output logic          OUT_LAST,
  output logic          OUT_IFFT,
  output logic          ERR
);

  localparam int OB = NB + 4;
  localparam int OW = (CAP_OFS < 2) ? 1 : $clog2(CAP_OFS + 1);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t        state;
  logic [NB-1:0] in_re_mem  [16];
  logic [NB-1:0] in_im_mem  [16];
  logic [OB-1:0] out_re_mem [16];
  logic [OB-1:0] out_im_mem [16];
  logic [3:0]    wr_ptr;
  logic [3:0]    rd_ptr;
  logic [3:0]    cap_idx;
  logic [4:0]    feed_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [OW-1:0] ofs_cnt;
  logic          armed;
  logic          in_full;
  logic          in_full_nxt;
  logic          in_ready;
  logic          in_mode;
  logic          out_full;
  logic          out_mode;
  logic          in_hs;
  logic          out_hs;
  logic          rdy_first;
  logic          cap_now;
  logic          feed_last;
  logic          timeout;

  assign in_hs  = IN_VALID & in_ready;
  assign out_hs = out_full & OUT_READY;

  // With CAP_OFS==0 the RDY cycle itself carries bin 0, so capture starts before armed is set.
  always_comb begin
    rdy_first   = (state == S_RUN) && !armed && FFT_RDY;
    cap_now     = (state == S_RUN) &&
                  ((armed && (ofs_cnt == OW'(CAP_OFS))) || (rdy_first && (CAP_OFS == 0)));
    feed_last   = (state == S_RUN) && (feed_cnt == 5'd15);
    timeout     = (state == S_RUN) && !armed && !FFT_RDY && (tmo_cnt == TW'(RDY_TIMEOUT - 1));
    in_full_nxt = in_full;
    if (in_hs && (wr_ptr == 4'd15)) in_full_nxt = 1'b1;
    if (feed_last || timeout)       in_full_nxt = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cap_idx   <= '0;
      feed_cnt  <= '0;
      tmo_cnt   <= '0;
      ofs_cnt   <= '0;
      armed     <= 1'b0;
      in_full   <= 1'b0;
      in_ready  <= 1'b0;
      in_mode   <= 1'b0;
      out_full  <= 1'b0;
      out_mode  <= 1'b0;
      FFT_ED    <= 1'b0;
      FFT_START <= 1'b0;
      FFT_IFFT  <= 1'b0;
      FFT_DIR   <= '0;
      FFT_DII   <= '0;
      ERR       <= 1'b0;
    end else begin
      in_full   <= in_full_nxt;
      in_ready  <= ~in_full_nxt;
      FFT_START <= 1'b0;
      if (in_hs) begin
        wr_ptr <= wr_ptr + 4'd1;
        if (wr_ptr == 4'd0) in_mode <= IN_IFFT;
      end
      if (out_hs) begin
        rd_ptr <= rd_ptr + 4'd1;
        if (rd_ptr == 4'd15) out_full <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (in_full && !out_full) begin
            state     <= S_START;
            FFT_START <= 1'b1;
            FFT_IFFT  <= in_mode;
            feed_cnt  <= '0;
            tmo_cnt   <= '0;
            ofs_cnt   <= '0;
            cap_idx   <= '0;
            armed     <= 1'b0;
          end
        end
        S_START: begin
          state   <= S_RUN;
          FFT_ED  <= 1'b1;
          FFT_DIR <= in_re_mem[0];
          FFT_DII <= in_im_mem[0];
        end
        S_RUN: begin
          // FFT_DIR/DII are registered one cycle ahead of the sample index they carry.
          if (feed_cnt != 5'd16) feed_cnt <= feed_cnt + 5'd1;
          if (feed_cnt < 5'd15) begin
            FFT_DIR <= in_re_mem[feed_cnt[3:0] + 4'd1];
            FFT_DII <= in_im_mem[feed_cnt[3:0] + 4'd1];
          end else begin
            FFT_DIR <= '0;
            FFT_DII <= '0;
          end
          if (!armed) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (FFT_RDY) begin
              armed   <= 1'b1;
              ofs_cnt <= (CAP_OFS == 0) ? OW'(0) : OW'(1);
            end
          end else if (ofs_cnt != OW'(CAP_OFS)) begin
            ofs_cnt <= ofs_cnt + OW'(1);
          end
          if (cap_now) begin
            cap_idx <= cap_idx + 4'd1;
            if (cap_idx == 4'd15) begin
              out_full <= 1'b1;
              out_mode <= FFT_IFFT;
            end
          end
          if (timeout) ERR <= 1'b1;
          if ((cap_now && (cap_idx == 4'd15)) || timeout) begin
            state   <= S_IDLE;
            FFT_ED  <= 1'b0;
            FFT_DIR <= '0;
            FFT_DII <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (in_hs) begin
      in_re_mem[wr_ptr] <= IN_RE;
      in_im_mem[wr_ptr] <= IN_IM;
    end
    if (cap_now) begin
      out_re_mem[cap_idx] <= FFT_DOR;
      out_im_mem[cap_idx] <= FFT_DOI;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_full;
  assign OUT_RE    = out_full ? out_re_mem[rd_ptr] : '0;
  assign OUT_IM    = out_full ? out_im_mem[rd_ptr] : '0;
  assign OUT_IDX   = rd_ptr;
  assign OUT_LAST  = out_full && (rd_ptr == 4'd15);
  assign OUT_IFFT  = out_full && out_mode;

endmodule

// File: tb/tb_fft16_frame_seq.sv
// tb/tb_fft16_frame_seq.sv - scoreboard bench for fft16_frame_seq with a behavioural DFT core model
// Stimulus pushes expected bins; a monitor pops them on every output handshake.
module tb_fft16_frame_seq;

  localparam int  NB          = 32;
  localparam int  OB          = NB + 4;
  localparam int  RDY_TIMEOUT = 64;
  localparam real PI          = 3.14159265358979;

  typedef longint frame_t [16];
  typedef struct {
    logic [OB-1:0] re;
    logic [OB-1:0] im;
    logic [3:0]    idx;
    logic          ifft;
  } exp_t;

  logic          CLK;
  logic          RSTN;
  logic          IN_VALID;
  logic          IN_READY;
  logic [NB-1:0] IN_RE;
  logic [NB-1:0] IN_IM;
  logic          IN_IFFT;
  logic          FFT_ED;
  logic          FFT_START;
  logic          FFT_IFFT;
  logic [NB-1:0] FFT_DIR;
  logic [NB-1:0] FFT_DII;
  logic          FFT_RDY;
  logic [OB-1:0] FFT_DOR;
  logic [OB-1:0] FFT_DOI;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [OB-1:0] OUT_RE;
  logic [OB-1:0] OUT_IM;
  logic [3:0]    OUT_IDX;
  logic          OUT_LAST;
  logic          OUT_IFFT;
  logic          ERR;

  int   checks;
  int   failures;
  int   ready_mode;
  bit   rdy_en;
  exp_t exp_q[$];

  fft16_frame_seq #(.NB(NB), .CAP_OFS(0), .RDY_TIMEOUT(RDY_TIMEOUT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_RE(IN_RE), .IN_IM(IN_IM), .IN_IFFT(IN_IFFT),
    .FFT_ED(FFT_ED), .FFT_START(FFT_START), .FFT_IFFT(FFT_IFFT),
    .FFT_DIR(FFT_DIR), .FFT_DII(FFT_DII),
    .FFT_RDY(FFT_RDY), .FFT_DOR(FFT_DOR), .FFT_DOI(FFT_DOI),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RE(OUT_RE), .OUT_IM(OUT_IM),
    .OUT_IDX(OUT_IDX), .OUT_LAST(OUT_LAST), .OUT_IFFT(OUT_IFFT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unscaled 16-point DFT; the inverse uses the positive exponent.
  function automatic void dft(input frame_t xr, input frame_t xi, input bit inv,
                              output frame_t yr, output frame_t yi);
    real ar, ai, th, c, s;
    for (int k = 0; k < 16; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 16; n++) begin
        th = 2.0 * PI * real'((n * k) % 16) / 16.0;
        c  = $cos(th);
        s  = inv ? $sin(th) : -$sin(th);
        ar = ar + real'(xr[n]) * c - real'(xi[n]) * s;
        ai = ai + real'(xi[n]) * c + real'(xr[n]) * s;
      end
      yr[k] = longint'($rtoi(ar >= 0.0 ? ar + 0.5 : ar - 0.5));
      yi[k] = longint'($rtoi(ai >= 0.0 ? ai + 0.5 : ai - 0.5));
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_frame(input frame_t yr, input frame_t yi, input bit m);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.re   = OB'(yr[k]);
      e.im   = OB'(yi[k]);
      e.idx  = 4'(k);
      e.ifft = m;
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_frame(output frame_t fr, output frame_t fi);
    for (int i = 0; i < 16; i++) begin
      fr[i] = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
      fi[i] = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
    end
  endtask

  task automatic send_frame(input frame_t fr, input frame_t fi, input bit m);
    int n;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_RE    = NB'(fr[i]);
      IN_IM    = NB'(fi[i]);
      IN_IFFT  = (i == 0) ? m : 1'($urandom);
      n = 0;
      while (!IN_READY && n < 3000) begin
        @(negedge CLK);
        n++;
      end
      if (n >= 3000) chk("in_accept_timeout", 0, 1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!FFT_START && n < 3000);
    if (!FFT_START) chk("start_seen", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_queue_left", longint'(exp_q.size()), 0);
  endtask

  // Core model: takes 16 samples on the ED cycles after START, raises RDY with bin 0 at ED cycle lat.
  initial begin
    frame_t cx_re, cx_im, cy_re, cy_im;
    int ed_idx = 1000;
    int lat    = 16;
    FFT_RDY = 1'b0;
    FFT_DOR = '0;
    FFT_DOI = '0;
    forever begin
      @(posedge CLK);
      #1;
      FFT_RDY = 1'b0;
      FFT_DOR = OB'({$urandom, $urandom});
      FFT_DOI = OB'({$urandom, $urandom});
      if (FFT_START) begin
        ed_idx = 0;
        lat    = $urandom_range(16, 40);
      end else if (FFT_ED) begin
        if (ed_idx < 16) begin
          cx_re[ed_idx] = longint'($signed(FFT_DIR));
          cx_im[ed_idx] = longint'($signed(FFT_DII));
        end
        if (ed_idx == lat) dft(cx_re, cx_im, FFT_IFFT, cy_re, cy_im);
        if (rdy_en && ed_idx >= lat && ed_idx < lat + 16) begin
          FFT_RDY = (ed_idx == lat);
          FFT_DOR = OB'(cy_re[ed_idx - lat]);
          FFT_DOI = OB'(cy_im[ed_idx - lat]);
        end
        ed_idx++;
      end
    end
  end

  initial begin
    OUT_READY = 1'b0;
    forever begin
      @(negedge CLK);
      case (ready_mode)
        0:       OUT_READY = ($urandom_range(0, 3) != 0);
        1:       OUT_READY = 1'b0;
        default: OUT_READY = 1'b1;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (RSTN && OUT_VALID && OUT_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected actual idx=%0d re=%0d required no output", OUT_IDX, $signed(OUT_RE));
        end else begin
          e = exp_q.pop_front();
          if (OUT_RE !== e.re || OUT_IM !== e.im || OUT_IDX !== e.idx ||
              OUT_LAST !== (e.idx == 4'd15) || OUT_IFFT !== e.ifft) begin
            failures++;
            $display("FAIL out_beat actual re=%0d im=%0d idx=%0d last=%0b ifft=%0b required re=%0d im=%0d idx=%0d last=%0b ifft=%0b",
                     $signed(OUT_RE), $signed(OUT_IM), OUT_IDX, OUT_LAST, OUT_IFFT,
                     $signed(e.re), $signed(e.im), e.idx, (e.idx == 4'd15), e.ifft);
          end
        end
      end
    end
  end

  initial begin
    frame_t fr, fi, yr, yi;
    int n, n_ed, starts;
    checks = 0; failures = 0;
    ready_mode = 2; rdy_en = 1'b1;
    RSTN = 1'b0; IN_VALID = 1'b0; IN_RE = '0; IN_IM = '0; IN_IFFT = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_ctrl", longint'({IN_READY, FFT_ED, FFT_START, FFT_IFFT, OUT_VALID, OUT_LAST, OUT_IFFT, ERR, OUT_IDX}), 0);
    chk("reset_data", longint'((|FFT_DIR) | (|FFT_DII) | (|OUT_RE) | (|OUT_IM)), 0);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("ready_after_reset", longint'(IN_READY), 1);

    // Impulse -> every bin 1+0j.
    for (int i = 0; i < 16; i++) begin fr[i] = 0; fi[i] = 0; yr[i] = 1; yi[i] = 0; end
    fr[0] = 1;
    push_frame(yr, yi, 1'b0);
    send_frame(fr, fi, 1'b0);
    // DC 1000 -> bin0 16000, others 0, in both modes.
    for (int i = 0; i < 16; i++) begin fr[i] = 1000; fi[i] = 0; yr[i] = 0; yi[i] = 0; end
    yr[0] = 16000;
    push_frame(yr, yi, 1'b0);
    send_frame(fr, fi, 1'b0);
    push_frame(yr, yi, 1'b1);
    send_frame(fr, fi, 1'b1);
    wait_drain();

    // Random frames back to back under random output backpressure.
    ready_mode = 0;
    for (int f = 0; f < 5; f++) begin
      bit m;
      m = 1'($urandom);
      rand_frame(fr, fi);
      dft(fr, fi, m, yr, yi);
      push_frame(yr, yi, m);
      send_frame(fr, fi, m);
    end
    wait_drain();

    // Held output: second frame fills but START must be withheld.
    ready_mode = 1;
    rand_frame(fr, fi);
    dft(fr, fi, 1'b0, yr, yi);
    push_frame(yr, yi, 1'b0);
    send_frame(fr, fi, 1'b0);
    n = 0;
    while (!OUT_VALID && n < 500) begin @(negedge CLK); n++; end
    chk("bp_first_valid", longint'(OUT_VALID), 1);
    rand_frame(fr, fi);
    dft(fr, fi, 1'b1, yr, yi);
    push_frame(yr, yi, 1'b1);
    send_frame(fr, fi, 1'b1);
    chk("bp_in_ready_low", longint'(IN_READY), 0);
    starts = 0;
    repeat (100) begin
      @(negedge CLK);
      #1;
      if (FFT_START) starts++;
    end
    chk("bp_start_withheld", starts, 0);
    chk("bp_out_idx_held", longint'(OUT_IDX), 0);
    ready_mode = 2;
    wait_drain();

    // RDY never comes -> ERR after exactly RDY_TIMEOUT ED cycles.
    rdy_en = 1'b0;
    rand_frame(fr, fi);
    send_frame(fr, fi, 1'b0);
    wait_start();
    n_ed = 0; n = 0;
    while (!ERR && n < 300) begin
      @(negedge CLK);
      #1;
      if (FFT_ED && !ERR) n_ed++;
      n++;
    end
    chk("timeout_ed_cycles", n_ed, RDY_TIMEOUT);
    chk("timeout_err", longint'(ERR), 1);
    chk("timeout_ed_off", longint'(FFT_ED), 0);
    chk("timeout_out_valid", longint'(OUT_VALID), 0);
    chk("timeout_in_ready", longint'(IN_READY), 1);
    starts = 0;
    repeat (10) begin
      @(negedge CLK);
      #1;
      if (FFT_START) starts++;
    end
    chk("timeout_idle", starts, 0);
    chk("timeout_err_sticky", longint'(ERR), 1);
    rdy_en = 1'b1;

    // Async reset while feeding sample 7.
    for (int i = 0; i < 16; i++) begin fr[i] = 0; fi[i] = 0; yr[i] = 1; yi[i] = 0; end
    fr[0] = 1;
    send_frame(fr, fi, 1'b0);
    wait_start();
    n_ed = 0; n = 0;
    while (n_ed < 8 && n < 100) begin
      @(negedge CLK);
      #1;
      if (FFT_ED) n_ed++;
      n++;
    end
    chk("mid_run_reached", n_ed, 8);
    RSTN = 1'b0;
    #1;
    chk("async_reset_ctrl", longint'({IN_READY, FFT_ED, FFT_START, FFT_IFFT, OUT_VALID, OUT_LAST, OUT_IFFT, ERR, OUT_IDX}), 0);
    chk("async_reset_data", longint'((|FFT_DIR) | (|FFT_DII) | (|OUT_RE) | (|OUT_IM)), 0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_reset_ready", longint'(IN_READY), 1);
    push_frame(yr, yi, 1'b0);
    send_frame(fr, fi, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
